// File: rtl/stepper_move_ctrl.sv
// stepper_move_ctrl: command-driven half-step sequencer for a 4-coil stepper
//   clock, reset              : system clock, synchronous active-high reset
//   cmd_valid/ready/dir/steps/period : move request handshake and parameters
//   abort                     : stop the current move after this cycle
//   stepperPins               : registered coil drive (half-step pattern)
//   busy/done/aborted         : RUN flag, end-of-move pulse, abort qualifier
//   position                  : signed absolute half-step position (wraps)
module stepper_move_ctrl #(
   parameter int COUNT_W    = 16,
   parameter int MIN_PERIOD = 50000,
   parameter bit HOLD       = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_dir,
   input  logic [COUNT_W-1:0] cmd_steps,
   input  logic [31:0]        cmd_period,
   input  logic               abort,
   output logic [3:0]         stepperPins,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [31:0]        position
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;
   localparam logic [31:0] MIN_P = 32'(MIN_PERIOD);
   // half-step pattern, phase 0 in the low nibble
   localparam logic [31:0] TBL = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                  4'b0110, 4'b0100, 4'b1100, 4'b1000};
   localparam logic [3:0] PINS_RST = HOLD ? 4'b1000 : 4'b0000;

   logic [1:0]         state_q, state_d;
   logic [2:0]         phase_q, phase_d;
   logic [31:0]        pos_q, pos_d;
   logic [31:0]        cnt_q, cnt_d;
   logic [31:0]        per_q, per_d;
   logic [COUNT_W-1:0] rem_q, rem_d;
   logic               dir_q, dir_d;
   logic               ab_q, ab_d;
   logic [3:0]         pins_q, pins_d;
   logic               accept, step;

   assign cmd_ready   = (state_q == S_IDLE) & ~reset & ~abort;
   assign accept      = cmd_valid & cmd_ready;
   assign step        = (state_q == S_RUN) && (cnt_q == per_q - 32'd1);
   assign busy        = state_q == S_RUN;
   assign done        = state_q == S_FIN;
   assign aborted     = ab_q;
   assign position    = pos_q;
   assign stepperPins = pins_q;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      pos_d   = pos_q;
      cnt_d   = cnt_q;
      per_d   = per_q;
      rem_d   = rem_q;
      dir_d   = dir_q;
      ab_d    = 1'b0;
      case (state_q)
         S_IDLE: if (accept) begin
            dir_d   = cmd_dir;
            rem_d   = cmd_steps;
            per_d   = (cmd_period < MIN_P) ? MIN_P : cmd_period;
            cnt_d   = '0;
            state_d = (cmd_steps != '0) ? S_RUN : S_FIN;
         end
         S_RUN: begin
            cnt_d = step ? 32'd0 : cnt_q + 32'd1;
            if (step) begin
               phase_d = dir_q ? phase_q + 3'd1 : phase_q - 3'd1;
               pos_d   = dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
               rem_d   = rem_q - COUNT_W'(1);
            end
            // a final step always completes normally, even with abort raised
            if (step && rem_q == COUNT_W'(1)) state_d = S_FIN;
            else if (abort) begin
               state_d = S_FIN;
               ab_d    = 1'b1;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      pins_d = (state_d == S_IDLE && !HOLD) ? 4'b0000 : TBL[{phase_d, 2'b00} +: 4];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         phase_q <= '0;
         pos_q   <= '0;
         cnt_q   <= '0;
         per_q   <= '0;
         rem_q   <= '0;
         dir_q   <= 1'b0;
         ab_q    <= 1'b0;
         pins_q  <= PINS_RST;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         pos_q   <= pos_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
         ab_q    <= ab_d;
         pins_q  <= pins_d;
      end
   end
endmodule
